// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: reset vector, instruction-memory geometry and the queued entry type.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam int          IM_ADDR_W = 10;
    localparam int          INSTR_W   = 32;
    localparam int          BUF_DEPTH = 2;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Word index of a byte address, as seen by the instruction memory.
    function automatic logic [IM_ADDR_W-1:0] word_idx(input logic [31:0] byte_addr);
        return byte_addr[IM_ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect input, instruction-memory port and decode handshake.
interface pc_fetch_unit_if;
    import mips_pkg::*;

    logic                 redirect_valid;
    logic [31:0]          redirect_addr;
    logic                 im_req_en;
    logic [IM_ADDR_W-1:0] im_req_addr;
    logic [INSTR_W-1:0]   im_rdata;
    logic                 if_valid;
    logic                 if_ready;
    logic [INSTR_W-1:0]   if_instr;
    logic [31:0]          if_pc;
    logic [IM_ADDR_W-1:0] im_out_addr;
    logic                 misalign_err;

    modport master (
        input  redirect_valid, redirect_addr, im_rdata, if_ready,
        output im_req_en, im_req_addr, if_valid, if_instr, if_pc, im_out_addr, misalign_err
    );

    modport slave (
        output redirect_valid, redirect_addr, im_rdata, if_ready,
        input  im_req_en, im_req_addr, if_valid, if_instr, if_pc, im_out_addr, misalign_err
    );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, instr}; flush beats push, a pop alongside a flush is still consumed.
module fetch_buf
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entries_q [BUF_DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) wr_ptr_d = ~wr_ptr_q;
            if (pop_i)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) entries_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = entries_q[rd_ptr_q];

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-cycle-latency memory reads and queues results for decode.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_unit_if.master   bus
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         inflight_q, inflight_d;
    logic         epoch_q, epoch_d;
    logic         req_epoch_q;
    logic [31:0]  req_pc_q;
    logic         misalign_q, misalign_d;

    logic         redirect;
    logic         pop;
    logic         push;
    logic         issue;
    logic         head_valid;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    assign redirect   = bus.redirect_valid & ~rst;
    assign head_valid = ~rst & (count != 2'd0);
    assign pop        = head_valid & bus.if_ready;

    // Entries held after this cycle, counting the outstanding read.
    assign occupancy  = {1'b0, count} + 3'(inflight_q) - 3'(pop);
    assign issue      = ~rst & ~redirect & (occupancy < 3'(BUF_DEPTH));

    // Responses tagged with a stale epoch belong to a flushed path.
    assign push       = inflight_q & (req_epoch_q == epoch_q) & ~redirect;
    assign push_entry = '{pc: req_pc_q, instr: bus.im_rdata};

    fetch_buf u_fetch_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .count_o     (count),
        .head_o      (head)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = issue;
        epoch_d    = epoch_q;
        misalign_d = 1'b0;
        if (redirect) begin
            fetch_pc_d = {bus.redirect_addr[31:2], 2'b00};
            epoch_d    = ~epoch_q;
            misalign_d = (bus.redirect_addr[1:0] != 2'b00);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC_P;
            inflight_q <= 1'b0;
            epoch_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            epoch_q    <= epoch_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q    <= fetch_pc_q;
        req_epoch_q <= epoch_q;
    end

    assign bus.im_req_en    = issue;
    assign bus.im_req_addr  = rst ? word_idx(RESET_PC_P) : word_idx(fetch_pc_q);
    assign bus.if_valid     = head_valid;
    assign bus.if_instr     = head_valid ? head.instr : NOP;
    assign bus.if_pc        = head_valid ? head.pc : 32'h0000_0000;
    assign bus.im_out_addr  = word_idx(bus.if_pc);
    assign bus.misalign_err = misalign_q & ~rst;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: startup, stall, redirects, reset flush and PC wrap.
module tb_pc_fetch_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC_P(32'h0000_3000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory: word at index i in the 0x3xxx page holds its pc ^ A5A5A5A5.
    always @(posedge clk) begin
        if (bus.im_req_en) bus.im_rdata <= {20'h00003, bus.im_req_addr, 2'b00} ^ 32'hA5A5_A5A5;
        else               bus.im_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
        chk({tag, "_pc"}, bus.if_pc, pc);
        chk({tag, "_instr"}, bus.if_instr, pc ^ 32'hA5A5_A5A5);
        chk({tag, "_outaddr"}, 32'(bus.im_out_addr), 32'(pc[11:2]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'h0;
        bus.if_ready       = 1'b1;
        tick(); tick();
        settle();
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_instr", bus.if_instr, 32'h0);
        chk("rst_req_en", 32'(bus.im_req_en), 32'd0);
        chk("rst_req_addr", 32'(bus.im_req_addr), 32'h000);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);

        // Startup: cycle 0 is the first cycle with rst low.
        tick(); rst = 1'b0; settle();
        chk("c0_req_en", 32'(bus.im_req_en), 32'd1);
        chk("c0_req_addr", 32'(bus.im_req_addr), 32'h000);
        chk("c0_valid", 32'(bus.if_valid), 32'd0);
        tick(); settle();
        chk("c1_valid", 32'(bus.if_valid), 32'd0);
        chk("c1_req_addr", 32'(bus.im_req_addr), 32'h001);
        tick(); settle();
        head("c2", 32'h0000_3000);
        chk("c2_instr_lit", bus.if_instr, 32'hA5A5_95A5);
        tick(); settle();
        head("c3", 32'h0000_3004);

        // Stall five cycles on the 0x3008 head.
        tick(); bus.if_ready = 1'b0; settle();
        head("stall0", 32'h0000_3008);
        chk("stall0_req_en", 32'(bus.im_req_en), 32'd0);
        for (int i = 1; i < 5; i++) begin
            tick(); settle();
            chk("stall_pc", bus.if_pc, 32'h0000_3008);
            chk("stall_req_en", 32'(bus.im_req_en), 32'd0);
        end
        tick(); bus.if_ready = 1'b1; settle();
        head("rel0", 32'h0000_3008);
        chk("rel0_req_en", 32'(bus.im_req_en), 32'd1);
        tick(); settle();
        head("rel1", 32'h0000_300C);
        tick(); settle();
        head("rel2", 32'h0000_3010);
        tick(); settle();
        head("rel3", 32'h0000_3014);

        // Aligned redirect in cycle N with 0x3018 at the head.
        tick(); bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h0000_3040; settle();
        head("rdN", 32'h0000_3018);
        chk("rdN_req_en", 32'(bus.im_req_en), 32'd0);
        tick(); bus.redirect_valid = 1'b0; settle();
        chk("rdN1_valid", 32'(bus.if_valid), 32'd0);
        chk("rdN1_req_en", 32'(bus.im_req_en), 32'd1);
        chk("rdN1_req_addr", 32'(bus.im_req_addr), 32'h010);
        chk("rdN1_misalign", 32'(bus.misalign_err), 32'd0);
        tick(); settle();
        chk("rdN2_valid", 32'(bus.if_valid), 32'd0);
        tick(); settle();
        head("rdN3", 32'h0000_3040);
        tick(); settle();
        head("rdN4", 32'h0000_3044);

        // Misaligned redirect.
        tick(); bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h0000_3043; settle();
        chk("maN_misalign", 32'(bus.misalign_err), 32'd0);
        tick(); bus.redirect_valid = 1'b0; settle();
        chk("maN1_misalign", 32'(bus.misalign_err), 32'd1);
        chk("maN1_valid", 32'(bus.if_valid), 32'd0);
        chk("maN1_req_addr", 32'(bus.im_req_addr), 32'h010);
        tick(); settle();
        chk("maN2_misalign", 32'(bus.misalign_err), 32'd0);
        tick(); settle();
        head("maN3", 32'h0000_3040);

        // Fill the queue, then pulse reset.
        tick(); bus.if_ready = 1'b0; settle();
        head("prerst", 32'h0000_3044);
        tick(); rst = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h0000_3100; settle();
        chk("rstp_valid", 32'(bus.if_valid), 32'd0);
        chk("rstp_pc", bus.if_pc, 32'h0);
        chk("rstp_req_en", 32'(bus.im_req_en), 32'd0);
        chk("rstp_req_addr", 32'(bus.im_req_addr), 32'h000);
        tick(); rst = 1'b0; bus.redirect_valid = 1'b0; bus.if_ready = 1'b1; settle();
        chk("rst0_valid", 32'(bus.if_valid), 32'd0);
        chk("rst0_req_en", 32'(bus.im_req_en), 32'd1);
        chk("rst0_req_addr", 32'(bus.im_req_addr), 32'h000);
        tick(); settle();
        chk("rst1_valid", 32'(bus.if_valid), 32'd0);
        tick(); settle();
        head("rst2", 32'h0000_3000);
        tick(); settle();
        head("rst3", 32'h0000_3004);

        // Back-to-back redirects: the second target wins.
        tick(); bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h0000_3100; settle();
        tick(); bus.redirect_addr = 32'h0000_3200; settle();
        chk("bbN1_valid", 32'(bus.if_valid), 32'd0);
        chk("bbN1_req_en", 32'(bus.im_req_en), 32'd0);
        tick(); bus.redirect_valid = 1'b0; settle();
        chk("bbN2_req_addr", 32'(bus.im_req_addr), 32'h080);
        chk("bbN2_req_en", 32'(bus.im_req_en), 32'd1);
        tick(); settle();
        chk("bbN3_valid", 32'(bus.if_valid), 32'd0);
        tick(); settle();
        head("bbN4", 32'h0000_3200);

        // PC wrap at the top of the address space.
        tick(); bus.redirect_valid = 1'b1; bus.redirect_addr = 32'hFFFF_FFFC; settle();
        tick(); bus.redirect_valid = 1'b0; settle();
        chk("wr1_req_addr", 32'(bus.im_req_addr), 32'h3FF);
        tick(); settle();
        chk("wr2_req_addr", 32'(bus.im_req_addr), 32'h000);
        tick(); settle();
        chk("wr3_pc", bus.if_pc, 32'hFFFF_FFFC);
        chk("wr3_outaddr", 32'(bus.im_out_addr), 32'h3FF);
        tick(); settle();
        chk("wr4_pc", bus.if_pc, 32'h0000_0000);
        chk("wr4_valid", 32'(bus.if_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of NextPCcalculator.
- Owns the architectural PC and issues word reads to the synchronous instruction memory.
- Buffers returned instructions in a 2-entry queue and presents {pc, instr} to decode over a valid/ready handshake.
- Accepts redirects (beq taken, j) computed by NextPCcalculator and drives im_out_addr back to it.

Parameters:
- RESET_PC, 32'h0000_3000, byte address fetched first after reset.
- IM_ADDR_W, 10, instruction-memory word-index width.
- BUF_DEPTH, 2, fetch-queue entries; fixed at 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_addr  in  32  target byte address (npc_out_addr of NextPCcalculator).
- im_req_en  out  1  memory read strobe.
- im_req_addr  out  IM_ADDR_W  word index = fetch_pc[IM_ADDR_W+1:2].
- im_rdata  in  32  read data, valid exactly one cycle after the im_req_en cycle.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode accepts head.
- if_instr  out  32  head instruction.
- if_pc  out  32  head byte address.
- im_out_addr  out  IM_ADDR_W  if_pc[IM_ADDR_W+1:2], to NextPCcalculator.
- misalign_err  out  1  one-cycle pulse on a misaligned redirect.

Behaviour:
- State:
  - fetch_pc: 32-bit next address to request.
  - inflight: 1 bit; a request was issued last cycle.
  - epoch: 1 bit, tags requests.
  - queue: 2 x {pc, instr}, with count 0..2.
- Reset (rst=1 at an edge): fetch_pc=RESET_PC, inflight=0, count=0, epoch=0.
  - Outputs while rst is high: if_valid=0, if_instr=0, if_pc=0, im_req_en=0, misalign_err=0, im_req_addr=RESET_PC[IM_ADDR_W+1:2].
  - Reset mid-operation: the in-flight response is discarded and the queue is emptied. No output may reflect pre-reset state on the cycle after reset.
- pop = if_valid & if_ready.
- Issue rule: im_req_en = !rst & !redirect_valid & (count + inflight - pop < 2).
  - On issue: fetch_pc <= fetch_pc + 4, which wraps modulo 2^32.
  - im_req_addr wraps naturally at 2^IM_ADDR_W words.
- Response: in the cycle after an issue, im_rdata is written to the queue tail with the issued pc, only if the request's epoch equals the current epoch.
  - Queue writes never overflow; the issue rule guarantees this.
  - A write and a pop in the same cycle are both performed; count is unchanged.
- Latency:
  - Request in cycle R, data captured at the end of R+1, if_valid from R+2.
  - After rst falls in cycle 0: first issue in cycle 0, if_valid in cycle 2 with if_pc=RESET_PC.
- Throughput: with if_ready held high, one instruction per cycle in steady state, with consecutive pcs.
- Back-pressure: while if_ready=0, the head and its data stay stable. Issue stops once count + inflight reaches 2. No instruction is lost or duplicated.
- Redirect (redirect_valid=1 in cycle N):
  - A pop in cycle N completes normally; that instruction is consumed.
  - All other queue entries are flushed (count=0) and epoch toggles, so the response of the request issued in N-1 is dropped.
  - No issue in cycle N; fetch_pc <= {redirect_addr[31:2], 2'b00}.
  - Issue at the target in N+1; if_valid at the target in N+3.
  - if_valid=0 in N+1 and N+2.
- Misaligned redirect (redirect_addr[1:0] != 0): the low bits are cleared as above and misalign_err=1 in cycle N+1 only.
- Redirect during rst is ignored; reset has priority.
- Back-to-back redirects: the last one wins; each one flushes and toggles epoch.

Decomposition:
- Shared package mips_pkg:
  - RESET_PC, IM_ADDR_W, INSTR_W=32.
  - Typedef fetch_entry_t = {pc[31:0], instr[31:0]}.
  - Constant NOP=32'h0000_0000.
- One sub-module, fetch_buf: 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - flush has priority over push; pop is honoured in the same cycle as flush.

Test Plan:
- Reset then if_ready=1, memory returns instr=pc ^ 32'hA5A5_A5A5:
  - if_valid rises at cycle 2 with if_pc=32'h3000.
  - Then 32'h3004, 32'h3008 on consecutive cycles, with if_instr matching.
  - im_out_addr=10'h000, then 10'h001, 10'h002 (pc[11:2] wraps with IM_ADDR_W=10, so 32'h3000 maps to index 0).
- Stall: if_ready=0 for 5 cycles from the 32'h3008 head:
  - im_req_en goes low after 2 outstanding; head stays 32'h3008.
  - On release, 32'h3008, 32'h300C, 32'h3010 arrive with no gap, loss or repeat.
- Redirect to 32'h3040 in cycle N, if_ready=1:
  - The head popped in N is kept, and if_valid=0 in N+1 and N+2.
  - if_pc=32'h3040 in N+3, and the pre-redirect response is never output.
- Redirect to 32'h3043:
  - misalign_err=1 for exactly one cycle (N+1).
  - Fetch resumes at 32'h3040.
- rst asserted for one cycle while count=2 and inflight=1:
  - Next cycle if_valid=0.
  - if_pc=32'h3000 two cycles after rst falls, with no stale data.
- fetch_pc=32'hFFFF_FFFC:
  - The next issued pc is 32'h0000_0000.
  - im_req_addr sequence 10'h3FF, then 10'h000.
